svga_sync_gen: RTL and testbench
================================

# svga_sync_gen

Generates SVGA raster timing (horizontal/vertical sync, blanking, pixel coordinates) from a single clock. It is the producer of the `V_SYNC` pulse that the input-latency metrics logic consumes, and the coordinate source for the frame renderer. Default timing is 800x600 @ 72 Hz with a 50 MHz pixel rate, and geometry is parameterizable per axis.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch (pixels)
- `H_SYNC`, 120: horizontal sync width (pixels)
- `H_BP`, 64: horizontal back porch (pixels)
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch (lines)
- `V_SYNC`, 6: vertical sync width (lines)
- `V_BP`, 23: vertical back porch (lines)
- `SYNC_POL`, 1'b1: asserted level of `H_SYNC_O`/`V_SYNC_O`

Ports:
- `clk` input 1: single clock for the block.
- `rst_l` input 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `en` input 1: pixel advance enable. When 0, the generator stalls.
- `H_SYNC_O` output 1: horizontal sync.
- `V_SYNC_O` output 1: vertical sync. Wired to the metrics `V_SYNC` input.
- `BLANK` output 1: 1 outside the visible region.
- `col` output 11: current pixel column, range 0..H_TOTAL-1.
- `row` output 10: current line, range 0..V_TOTAL-1.
- `line_start` output 1: one-clk pulse when `col` wraps to 0.
- `frame_start` output 1: one-clk pulse when (`col`,`row`) wraps to (0,0).

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 1040 by default.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 666 by default.
- Reset values:
  - `col`=0, `row`=0
  - `H_SYNC_O`=`V_SYNC_O`=~SYNC_POL
  - `BLANK`=0
  - `line_start`=`frame_start`=0
  - both axis states are ACTIVE
- Each axis runs a 4-state FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE. State is derived from the axis counter, with transitions at these boundaries:
  - ACTIVE→FRONT at count = ACTIVE
  - FRONT→SYNC at ACTIVE+FP
  - SYNC→BACK at ACTIVE+FP+SYNC
  - BACK→ACTIVE at wrap to 0
- On each clk with `en`=1:
  - `col` increments.
  - At `col`=H_TOTAL-1, `col` wraps to 0 and `row` increments.
  - At `row`=V_TOTAL-1 with a column wrap, `row` wraps to 0.
- With `en`=0:
  - `col`, `row`, `H_SYNC_O`, `V_SYNC_O` and `BLANK` hold.
  - `line_start` and `frame_start` are 0.
- `H_SYNC_O`=SYNC_POL iff `col` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. With defaults this is [856, 975].
- `V_SYNC_O`=SYNC_POL iff `row` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. With defaults this is [637, 642]. It covers full lines, so it changes only when `col` changes to 0.
- `BLANK`=1 iff `col` ≥ H_ACTIVE or `row` ≥ V_ACTIVE.
- `line_start` is high for the single clk in which `col` has just become 0 through a wrap. It is not asserted out of reset.
- `frame_start` is high for the same clk as `line_start` when `row` has also just become 0. It implies `line_start`.
- Width rule: counter comparisons are unsigned at the port width. Parameters must satisfy H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024, checked by an elaboration-time assertion.

## Timing
- All outputs are registered and updated on the same clk edge as `col`/`row`. Decodes have zero-cycle skew relative to the coordinates they describe.
- Latency from `en` rising to first counter change is 1 clk.
- Line period is H_TOTAL enabled clks. Frame period is H_TOTAL·V_TOTAL enabled clks, which is 692640 by default.
- Reset mid-frame: asynchronous return to the reset values listed above, with no pulse on release. Counting resumes from (0,0) on the first enabled edge after `rst_l` deasserts.
- When the wrap at (H_TOTAL-1, V_TOTAL-1) occurs, `line_start` and `frame_start` both assert in the same clk.

## Structure
- Package `svga_pkg` holds:
  - the default timing localparams
  - `axis_state_t` enum {ACTIVE, FRONT, SYNC, BACK}
  - a `SYNC_POS`/`SYNC_NEG` polarity constant
- Sub-module `sync_axis` is instantiated twice (H, V). It contains:
  - a parameterized counter with `advance` and `wrap` outputs
  - the axis FSM
  - the sync and in-active decodes
- The V instance advances on the H instance's `wrap`.

## Test plan
- Reset, then hold `en`=0 for 10 clks → `col`=0, `row`=0, `H_SYNC_O`=0, `V_SYNC_O`=0, `BLANK`=0, no pulses.
- `en`=1 for one line → `BLANK` rises at `col`=800. `H_SYNC_O` is high exactly at `col` 856..975 (120 clks). `line_start` pulses 1040 clks after the first edge.
- Run a full frame → `V_SYNC_O` is high for rows 637..642 (6240 clks). `frame_start` pulses once every 692640 clks, coincident with `line_start`.
- Toggle `en` 1-on/1-off for 2100 clks → `col`/`row` advance only on enabled clks. Outputs hold while disabled, and no pulse lasts longer than 1 clk.
- Assert `rst_l`=0 at `row`=300, `col`=500 → outputs go to reset values immediately. After release, `col` counts from 0 and the next `frame_start` occurs 692640 enabled clks later.
- Instantiate with `SYNC_POL`=0, `H_TOTAL`=16 (H_ACTIVE 10/FP 2/SYNC 2/BP 2) and `V_TOTAL`=6 (V_ACTIVE 3/FP 1/SYNC 1/BP 1) → `H_SYNC_O` is low at `col` 12..13, `V_SYNC_O` is low at `row` 4, frame period is 96 clks.

Source files
------------

// File: rtl/svga_sync_gen_pkg.sv
// svga_pkg: shared timing defaults, polarity constants and the axis state type
// for the SVGA raster timing generator.
package svga_pkg;

    // 800x600 @ 72 Hz with a 50 MHz pixel clock
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;

    // Coordinate widths seen by consumers of the timing bus
    localparam int COL_W = 11;
    localparam int ROW_W = 10;

    // Asserted level of the sync outputs
    localparam logic SYNC_POS = 1'b1;
    localparam logic SYNC_NEG = 1'b0;

    // Region of one raster axis, in scan order
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

endpackage

// File: rtl/svga_sync_gen_if.sv
// svga_sync_gen_if: raster timing bus between the sync generator (master)
// and its consumers such as the frame renderer and latency metrics (slave).
interface svga_sync_gen_if;
    import svga_pkg::*;

    logic             en;
    logic             H_SYNC_O;
    logic             V_SYNC_O;
    logic             BLANK;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  en,
        output H_SYNC_O, V_SYNC_O, BLANK, col, row, line_start, frame_start
    );

    modport slave (
        output en,
        input  H_SYNC_O, V_SYNC_O, BLANK, col, row, line_start, frame_start
    );

endinterface

// File: rtl/svga_sync_gen_sync_axis.sv
// sync_axis: one raster axis (horizontal or vertical). Holds the position
// counter, the ACTIVE/FRONT/SYNC/BACK region FSM and the registered sync
// decode. The in-active decode is offered for the value about to be loaded so
// the parent can register it in lockstep with the counter.
module sync_axis
    import svga_pkg::*;
#(
    parameter int   ACT_LEN  = 800,
    parameter int   FP_LEN   = 56,
    parameter int   SYNC_LEN = 120,
    parameter int   BP_LEN   = 64,
    parameter int   W        = 11,
    parameter logic POL      = SYNC_POS
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         i_step,
    output logic [W-1:0] o_count,
    output logic         o_advance,
    output logic         o_wrap,
    output logic         o_sync,
    output logic         o_activeNext
);

    localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] FRONT_AT = W'(ACT_LEN);
    localparam logic [W-1:0] SYNC_AT  = W'(ACT_LEN + FP_LEN);
    localparam logic [W-1:0] BACK_AT  = W'(ACT_LEN + FP_LEN + SYNC_LEN);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_countNext;
    axis_state_t  r_state;
    axis_state_t  w_stateNext;
    logic         r_sync;

    assign o_advance    = i_step;
    assign o_wrap       = i_step && (r_count == LAST);
    assign o_count      = r_count;
    assign o_sync       = r_sync;
    assign o_activeNext = (w_stateNext == ACTIVE);

    // Position for the next edge: count up, wrap to 0 after the last position
    always_comb begin
        w_countNext = r_count;
        if (i_step) begin
            w_countNext = o_wrap ? '0 : (r_count + ONE);
        end
    end

    // Position counter register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_count <= '0;
        end else begin
            r_count <= w_countNext;
        end
    end

    // Region FSM state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ACTIVE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Region FSM next state: regions change only when the position lands on a boundary
    always_comb begin
        w_stateNext = r_state;
        if (i_step) begin
            if (w_countNext == '0) begin
                w_stateNext = ACTIVE;
            end else if (w_countNext == FRONT_AT) begin
                w_stateNext = FRONT;
            end else if (w_countNext == SYNC_AT) begin
                w_stateNext = SYNC;
            end else if (w_countNext == BACK_AT) begin
                w_stateNext = BACK;
            end
        end
    end

    // Sync output is registered from the next region so it never lags the counter
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sync <= ~POL;
        end else if (i_step) begin
            r_sync <= (w_stateNext == SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/svga_sync_gen.sv
// svga_sync_gen: SVGA raster timing generator. Two sync_axis instances form a
// column/row counter pair; the row axis advances when the column axis wraps.
// Every output on the bus is a flop updated on the same edge as col/row.
module svga_sync_gen
    import svga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = SYNC_POS
) (
    input logic             clk,
    input logic             rst_l,
    svga_sync_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Geometry must fit the coordinate widths of the bus
    generate
        if (H_TOTAL > (1 << COL_W)) begin : g_hTooLarge
            $error("svga_sync_gen: H_TOTAL exceeds the column counter range");
        end
        if (V_TOTAL > (1 << ROW_W)) begin : g_vTooLarge
            $error("svga_sync_gen: V_TOTAL exceeds the row counter range");
        end
    endgenerate

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_hAdvance;
    logic             w_hWrap;
    logic             w_hSync;
    logic             w_hActNext;
    logic             w_vAdvance;
    logic             w_vWrap;
    logic             w_vSync;
    logic             w_vActNext;
    logic             r_blank;
    logic             r_lineStart;
    logic             r_frameStart;

    sync_axis #(
        .ACT_LEN  (H_ACTIVE),
        .FP_LEN   (H_FP),
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP),
        .W        (COL_W),
        .POL      (SYNC_POL)
    ) u_hAxis (
        .clk          (clk),
        .rst_l        (rst_l),
        .i_step       (bus.en),
        .o_count      (w_col),
        .o_advance    (w_hAdvance),
        .o_wrap       (w_hWrap),
        .o_sync       (w_hSync),
        .o_activeNext (w_hActNext)
    );

    sync_axis #(
        .ACT_LEN  (V_ACTIVE),
        .FP_LEN   (V_FP),
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP),
        .W        (ROW_W),
        .POL      (SYNC_POL)
    ) u_vAxis (
        .clk          (clk),
        .rst_l        (rst_l),
        .i_step       (w_hWrap),
        .o_count      (w_row),
        .o_advance    (w_vAdvance),
        .o_wrap       (w_vWrap),
        .o_sync       (w_vSync),
        .o_activeNext (w_vActNext)
    );

    // Blanking follows the regions both axes are about to enter; holds while stalled
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_blank <= 1'b0;
        end else if (w_hAdvance) begin
            r_blank <= ~(w_hActNext & w_vActNext);
        end
    end

    // Line/frame pulses mark the edge on which the coordinates wrapped
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_lineStart  <= w_hWrap;
            r_frameStart <= w_vAdvance & w_vWrap;
        end
    end

    assign bus.col         = w_col;
    assign bus.row         = w_row;
    assign bus.H_SYNC_O    = w_hSync;
    assign bus.V_SYNC_O    = w_vSync;
    assign bus.BLANK       = r_blank;
    assign bus.line_start  = r_lineStart;
    assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_svga_sync_gen.sv
// tb_svga_sync_gen: drives a default-geometry generator and a tiny
// negative-polarity 16x6 generator with the same enable/reset stream.
// Expected bus values come from an arithmetic raster model indexed by the
// number of enabled clocks since reset; a monitor pops and compares each cycle.
module tb_svga_sync_gen;

   typedef struct packed {
      logic [10:0] col;
      logic [9:0]  row;
      logic        hs;
      logic        vs;
      logic        blank;
      logic        ls;
      logic        fs;
   } exp_t;

   typedef struct {
      int   ha, hfp, hsw, hbp;
      int   va, vfp, vsw, vbp;
      logic pol;
   } geom_t;

   logic clk;
   logic rstL;

   exp_t  qDef[$];
   exp_t  qSmall[$];
   geom_t gDef;
   geom_t gSmall;
   longint nEnabled;

   int assertCount;
   int failCount;

   svga_sync_gen_if ifDef ();
   svga_sync_gen_if ifSmall ();

   svga_sync_gen dutDef (
      .clk   (clk),
      .rst_l (rstL),
      .bus   (ifDef)
   );

   svga_sync_gen #(
      .H_ACTIVE (10), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (3),  .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1'b0)
   ) dutSmall (
      .clk   (clk),
      .rst_l (rstL),
      .bus   (ifSmall)
   );

   // Free-running pixel clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Raster position after n enabled clocks, from plain division and ranges
   function automatic exp_t model(input geom_t g, input longint n, input logic stepped);
      exp_t   e;
      longint ht, vt, c, r;
      ht = g.ha + g.hfp + g.hsw + g.hbp;
      vt = g.va + g.vfp + g.vsw + g.vbp;
      c  = n % ht;
      r  = (n / ht) % vt;
      e.col   = 11'(c);
      e.row   = 10'(r);
      e.hs    = (c >= g.ha + g.hfp && c < g.ha + g.hfp + g.hsw) ? g.pol : ~g.pol;
      e.vs    = (r >= g.va + g.vfp && r < g.va + g.vfp + g.vsw) ? g.pol : ~g.pol;
      e.blank = (c >= g.ha) || (r >= g.va);
      e.ls    = stepped && (n > 0) && (c == 0);
      e.fs    = e.ls && (r == 0);
      return e;
   endfunction

   // Single field comparison with failure report
   task automatic checkField(input string tag, input string name, input int act, input int exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s.%s actual=%0d expected=%0d at %0t", tag, name, act, exp, $time);
      end
   endtask

   // Compare a sampled bus snapshot against its expected snapshot
   task automatic checkOutput(input string tag, input exp_t act, input exp_t exp);
      checkField(tag, "col",         int'(act.col),   int'(exp.col));
      checkField(tag, "row",         int'(act.row),   int'(exp.row));
      checkField(tag, "H_SYNC_O",    int'(act.hs),    int'(exp.hs));
      checkField(tag, "V_SYNC_O",    int'(act.vs),    int'(exp.vs));
      checkField(tag, "BLANK",       int'(act.blank), int'(exp.blank));
      checkField(tag, "line_start",  int'(act.ls),    int'(exp.ls));
      checkField(tag, "frame_start", int'(act.fs),    int'(exp.fs));
   endtask

   // Queue the expected result of the coming edge for both instances
   task automatic pushExpected(input logic stepped);
      qDef.push_back(model(gDef, nEnabled, stepped));
      qSmall.push_back(model(gSmall, nEnabled, stepped));
   endtask

   // One clock of stimulus with reset released
   task automatic applyStimulus(input logic enVal);
      @(negedge clk);
      rstL       = 1'b1;
      ifDef.en   = enVal;
      ifSmall.en = enVal;
      if (enVal) nEnabled++;
      pushExpected(enVal);
   endtask

   // Asynchronous reset held for a number of clocks, checked as soon as it lands
   task automatic applyReset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rstL       = 1'b0;
         ifDef.en   = 1'($urandom_range(0, 1));
         ifSmall.en = ifDef.en;
         nEnabled   = 0;
         pushExpected(1'b0);
         if (i == 0) begin
            #1;
            checkField("def_async", "col",      int'(ifDef.col),        0);
            checkField("def_async", "row",      int'(ifDef.row),        0);
            checkField("def_async", "H_SYNC_O", int'(ifDef.H_SYNC_O),   0);
            checkField("small_async", "col",    int'(ifSmall.col),      0);
            checkField("small_async", "H_SYNC_O", int'(ifSmall.H_SYNC_O), 1);
         end
      end
   endtask

   // Monitor: one snapshot per clock, sampled just after the active edge
   always begin
      exp_t a;
      @(posedge clk);
      #1;
      if (qDef.size() > 0) begin
         a = {ifDef.col, ifDef.row, ifDef.H_SYNC_O, ifDef.V_SYNC_O,
              ifDef.BLANK, ifDef.line_start, ifDef.frame_start};
         checkOutput("def", a, qDef.pop_front());
      end
      if (qSmall.size() > 0) begin
         a = {ifSmall.col, ifSmall.row, ifSmall.H_SYNC_O, ifSmall.V_SYNC_O,
              ifSmall.BLANK, ifSmall.line_start, ifSmall.frame_start};
         checkOutput("small", a, qSmall.pop_front());
      end
   end

   // Stimulus sequence
   initial begin
      gDef   = '{ha: 800, hfp: 56, hsw: 120, hbp: 64,
                 va: 600, vfp: 37, vsw: 6, vbp: 23, pol: 1'b1};
      gSmall = '{ha: 10, hfp: 2, hsw: 2, hbp: 2,
                 va: 3, vfp: 1, vsw: 1, vbp: 1, pol: 1'b0};
      assertCount = 0;
      failCount   = 0;
      nEnabled    = 0;
      rstL        = 1'b0;
      ifDef.en    = 1'b0;
      ifSmall.en  = 1'b0;

      $display("[TB] reset then stalled");
      applyReset(3);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0);

      $display("[TB] continuous enable across a full default line");
      for (int i = 0; i < 1100; i++) applyStimulus(1'b1);

      $display("[TB] alternating enable");
      for (int i = 0; i < 2100; i++) applyStimulus(1'(i % 2 == 0));

      $display("[TB] random enable");
      for (int i = 0; i < 1500; i++) applyStimulus(1'($urandom_range(0, 3) != 0));

      $display("[TB] mid-frame reset and restart");
      applyReset(2);
      for (int i = 0; i < 1200; i++) applyStimulus(1'b1);
      for (int i = 0; i < 300; i++) applyStimulus(1'($urandom_range(0, 1)));

      @(negedge clk);
      ifDef.en   = 1'b0;
      ifSmall.en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkField("drain", "def_queue",   qDef.size(),   0);
      checkField("drain", "small_queue", qSmall.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
